oam_dma_ctrl: RTL

// Owns the single-port, synchronous-read system memory shared by the 6502 core and a page-copy DMA engine.
// A CPU store to TRIGGER_ADDR stalls the core through RDY, then copies LEN bytes from page {data,8'h00} to DEST_ADDR.
// It then hands the bus back. Sits between cpu (AB/DO/WE/RDY) and the memory array; memory read data is 1-cycle registered.

---
 rtl/dma_pkg.sv | 15 +
 rtl/oam_dma_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/dma_pkg.sv
// Shared types and fixed addresses for the OAM page-copy DMA controller.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    RD,
    WR,
    RESUME
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_TRIGGER = 16'h4014;
  localparam logic [15:0] OAM_DATA_PORT   = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Page-copy DMA engine sharing a single-port, registered-read memory with a 6502 core.
// A CPU store to TRIGGER_ADDR stalls the core and streams LEN bytes of a page to DEST_ADDR.
module oam_dma_ctrl
  import dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = OAM_DMA_TRIGGER,
  parameter logic [15:0] DEST_ADDR    = OAM_DATA_PORT,
  parameter int          LEN          = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] mem_ab,
  output logic [7:0]  mem_do,
  output logic        mem_we,
  input  logic [7:0]  mem_di,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam int IDX_W = $clog2(LEN);

  dma_state_t       state;
  dma_state_t       state_next;
  logic [7:0]       page;
  logic [IDX_W-1:0] idx;
  logic             trigger;
  logic             last;
  logic [15:0]      src_addr;

  assign trigger  = cpu_we && (cpu_ab == TRIGGER_ADDR);
  assign last     = (idx == IDX_W'(LEN - 1));
  assign src_addr = {page, 8'(idx)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Source page and byte index; idx only advances after a byte has been written out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page <= 8'h00;
      idx  <= '0;
    end else if (state == IDLE && trigger) begin
      page <= cpu_do;
      idx  <= '0;
    end else if (state == WR && !last) begin
      idx <= idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_ab     = cpu_ab;
    mem_do     = cpu_do;
    mem_we     = cpu_we;
    case (state)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      // The core ignores RDY on write cycles, so wait for its stores to finish.
      HALT: begin
        if (!cpu_we) state_next = RD;
      end
      RD: begin
        mem_ab     = src_addr;
        mem_do     = mem_di;
        mem_we     = 1'b0;
        state_next = WR;
      end
      WR: begin
        mem_ab     = DEST_ADDR;
        mem_do     = mem_di;
        mem_we     = 1'b1;
        state_next = last ? RESUME : RD;
      end
      // CPU owns the bus again so its held address is re-read into DI before RDY rises.
      RESUME: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign cpu_rdy  = (state == IDLE);
  assign dma_busy = (state != IDLE);
  assign dma_done = (state == RESUME);

endmodule
